// File: rtl/imem_uart_loader.sv
// imem_uart_loader: assembles a length-prefixed little-endian UART byte stream into imem writes.
// Optional checksum trailer byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
`default_nettype none

module imem_uart_loader #(
  parameter int MEM_WORDS      = 16384,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        we,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        load_done,
  output logic        load_err,
  output logic        cpu_rst_n
);

  localparam int WCW = $clog2(MEM_WORDS + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERR} state_t;
`endif

  state_t          state_q, state_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [31:0]     len_q, len_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic [31:0]     asm_q, asm_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            we_q, we_d;
  logic [31:0]     wr_addr_q, wr_addr_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic [31:0] len_full;
  logic        last_word;
  logic        active;
  state_t      end_state;

  always_comb begin
    len_full  = {rx_data, len_q[23:0]};
    last_word = (32'(word_cnt_q) + 32'd1) == len_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    end_state = S_CSUM;
    active    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
    end_state = S_DONE;
    active    = (state_q == S_LEN) || (state_q == S_DATA);
`endif
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    timer_d    = timer_q;
    we_d       = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (active) timer_d = rx_valid ? '0 : timer_q + TW'(1);

    case (state_q)
      S_IDLE: if (rx_valid) begin
        len_d      = {24'b0, rx_data};
        byte_idx_d = 2'd1;
        timer_d    = '0;
        state_d    = S_LEN;
      end
      S_LEN: if (rx_valid) begin
        len_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          if (len_full == 32'd0)                 state_d = end_state;
          else if (len_full > 32'(MEM_WORDS))    state_d = S_ERR;
          else                                   state_d = S_DATA;
        end
      end
      S_DATA: if (rx_valid) begin
        asm_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
        byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ rx_data;
`endif
        if (byte_idx_q == 2'd3) begin
          we_d       = 1'b1;
          wr_addr_d  = 32'(word_cnt_q) << 2;
          wr_data_d  = {rx_data, asm_q[23:0]};
          word_cnt_d = word_cnt_q + WCW'(1);
          if (last_word) state_d = end_state;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: if (rx_valid) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
`endif
      default: ;
    endcase

    // An arriving byte always beats the timeout in the same cycle.
    if (active && !rx_valid && (timer_q == T_LAST)) state_d = S_ERR;

`ifdef IMEM_LOADER_CHECKSUM_EN
    busy_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
`else
    busy_d = (state_d == S_LEN) || (state_d == S_DATA);
`endif
    // done trails the final write by a cycle; err is flagged as soon as ERR is entered.
    done_d = done_q | (state_q == S_DONE);
    err_d  = err_q  | (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      asm_q      <= '0;
      timer_q    <= '0;
      we_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      timer_q    <= timer_d;
      we_q       <= we_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign we        = we_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign cpu_rst_n = done_q;

endmodule

`default_nettype wire

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Upstream feeder of the instruction memory write port in the 3-stage pipeline.
- Takes a byte stream from the UART receiver and assembles it into little-endian 32-bit words.
- Issues one-cycle write strobes (we/wr_addr/wr_data) to instruction memory.
- Holds the core in reset until the program image has fully loaded, then releases it.

Parameters:
- MEM_WORDS, 16384, instruction memory depth in 32-bit words (64 KiB); maximum accepted image length.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between consecutive bytes once a transfer has started.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_valid  input  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  input  8  received byte.
- we  output  1  imem write strobe, one cycle per word.
- wr_addr  output  32  imem byte address; bits [1:0] always 0.
- wr_data  output  32  imem write word.
- busy  output  1  transfer in progress (states LEN or DATA).
- load_done  output  1  sticky: image loaded successfully.
- load_err  output  1  sticky: length overflow or timeout (checksum fail when feature enabled).
- cpu_rst_n  output  1  active-low reset to the core; equals load_done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; we=0, wr_addr=0, wr_data=0, busy=0, load_done=0, load_err=0, cpu_rst_n=0.
- Reset clears the byte counter, word counter, length register and timeout counter. Reset asserted mid-transfer aborts the transfer; no further we pulses occur.
- Image format:
  - 4 length bytes, little-endian, giving N in words.
  - Then N words, 4 bytes each, little-endian (first byte -> wr_data[7:0]).
- States:
  - IDLE -> LEN on the first rx_valid. That byte is the length byte 0.
  - LEN: collects 4 length bytes. After the 4th:
    - N==0 -> DONE.
    - N>MEM_WORDS -> ERR.
    - otherwise -> DATA.
  - DATA: a 2-bit byte index selects the shift lane. After the 4th byte of word k:
    - next cycle: we=1, wr_addr=k<<2, wr_data=assembled word; we=1 for exactly one cycle.
    - after word N-1 has been written -> DONE (load_done rises the cycle after the final we).
  - DONE: load_done=1, cpu_rst_n=1; all rx_valid ignored until reset.
  - ERR: load_err=1, cpu_rst_n stays 0; all rx_valid ignored until reset.
- Timeout:
  - Counter cleared on every accepted byte; counts only in LEN/DATA.
  - Reaching TIMEOUT_CYCLES -> ERR.
  - If rx_valid arrives in the same cycle the limit is reached, the byte wins: counter clears, no error.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss. The we pulse for word k may coincide with byte 0 of word k+1.
- Word counter is 15 bits, so N=MEM_WORDS=16384 is legal; final wr_addr=0x0000FFFC. No wrap.
- Length boundaries: N=16384 accepted; N=16385 -> ERR.
- Outputs are registered; wr_addr and wr_data hold their last value when we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last data word, one extra byte is expected, in state CSUM (DATA -> CSUM -> DONE/ERR).
  - The byte must equal the XOR of all 4N data bytes (length bytes excluded).
  - Match -> DONE; mismatch -> ERR.
  - For N==0, the checksum byte (expected 0x00) is still required.
  - The timeout also applies in CSUM.
- Disabled: no CSUM state; DONE immediately follows the last write.

Test Plan:
- Bytes 02 00 00 00, 13 05 00 00, 6F 00 00 00 sent back-to-back.
  -> we pulses: (0x0, 0x00000513), then (0x4, 0x0000006F).
  -> load_done=1, cpu_rst_n=1 one cycle after the 2nd we.
- Length 00 00 00 00.
  -> no we; load_done=1.
  -> with CHECKSUM_EN, a following byte 00 is required before load_done=1.
- Length 01 40 00 00 (N=16385).
  -> load_err=1, no we, cpu_rst_n=0.
  -> later bytes ignored.
- Length 01 00 00 00, then 2 data bytes, then idle for TIMEOUT_CYCLES (set to 50 in the bench).
  -> load_err=1 at cycle 50, no we.
- rst_n pulsed low after 6 of 8 data bytes, then a full valid image sent.
  -> outputs return to reset values immediately.
  -> new load writes from address 0 and completes.
- CHECKSUM_EN, N=1, word 0x11223344, checksum byte 0x44.
  -> we at 0x0; load_done=1.
  -> repeat with checksum byte 0x45 -> load_err=1 after the we.
